// File: rtl/instr_prefetch_queue_if.sv
// ============================================================================
// instr_prefetch_queue_if : fetch-side bus (memory req/ack + IF/ID valid/ready)
// Rev 1.0
// ============================================================================
`default_nettype none

interface instr_prefetch_queue_if;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  modport master (
    input  start_i, redirect_i, redirect_pc_i, mem_ack_i, mem_data_i, instr_ready_i,
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o
  );

  modport slave (
    output start_i, redirect_i, redirect_pc_i, mem_ack_i, mem_data_i, instr_ready_i,
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o
  );
endinterface

`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
// ============================================================================
// instr_prefetch_queue : sequential fetcher + {pc,instr} FIFO with redirect flush
// Optional PREFETCH_STATS_EN adds discard/stall counters.          Rev 1.0
// ============================================================================
`default_nettype none

module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire                    clk_i,
  input  wire                    rst_i,
  instr_prefetch_queue_if.master bus
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]            discard_cnt_o,
  output logic [15:0]            stall_cnt_o
`endif
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx;
  logic          mem_req, req_nx;
  logic [31:0]   mem_addr, addr_nx;
  logic [AW:0]   count, count_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];

  logic          ack, push, pop, can_issue, valid;
  logic [31:0]   target;

  assign valid = (count != '0);

  always_comb begin
    ack  = mem_req & bus.mem_ack_i;
    pop  = valid & bus.instr_ready_i & ~bus.redirect_i;
    push = ack & (state == REQ) & ~bus.redirect_i;
    if (bus.redirect_i)
      count_next = '0;
    else
      count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    // Space is judged after this cycle's push/pop, so a push can never find the FIFO full
    can_issue = bus.start_i & (count_next < FULL_COUNT);
    target    = bus.redirect_i ? bus.redirect_pc_i : fetch_pc;
  end

  always_comb begin
    state_nx    = state;
    req_nx      = mem_req;
    addr_nx     = mem_addr;
    fetch_pc_nx = bus.redirect_i ? bus.redirect_pc_i : fetch_pc;
    case (state)
      IDLE: begin
        if (can_issue) begin
          req_nx   = 1'b1;
          addr_nx  = target;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (bus.redirect_i) begin
          if (ack) begin
            req_nx   = can_issue;
            addr_nx  = can_issue ? target : mem_addr;
            state_nx = can_issue ? REQ : IDLE;
          end else begin
            state_nx = DRAIN;
          end
        end else if (ack) begin
          fetch_pc_nx = mem_addr + 32'd4;
          req_nx      = can_issue;
          addr_nx     = can_issue ? mem_addr + 32'd4 : mem_addr;
          state_nx    = can_issue ? REQ : IDLE;
        end
      end
      DRAIN: begin
        // Stale response: drop it and restart at the newest target
        if (ack) begin
          req_nx   = can_issue;
          addr_nx  = can_issue ? target : mem_addr;
          state_nx = can_issue ? REQ : IDLE;
        end
      end
      default: begin
        req_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      mem_req  <= req_nx;
      mem_addr <= addr_nx;
      count    <= count_next;
      if (bus.redirect_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc_q[wr_ptr]    <= mem_addr;
      instr_q[wr_ptr] <= bus.mem_data_i;
    end
  end

  assign bus.mem_req_o     = mem_req;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = valid ? instr_q[rd_ptr] : 32'h0;
  assign bus.pc_o          = valid ? pc_q[rd_ptr]    : 32'h0;

`ifdef PREFETCH_STATS_EN
  logic [15:0] discard_cnt, stall_cnt;
  logic [15:0] discard_inc;
  logic [16:0] discard_sum;

  always_comb begin
    discard_inc = '0;
    if (bus.redirect_i)
      discard_inc = 16'(count);
    if (ack && ((state == DRAIN) || ((state == REQ) && bus.redirect_i)))
      discard_inc = discard_inc + 16'd1;
    discard_sum = {1'b0, discard_cnt} + {1'b0, discard_inc};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      discard_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      discard_cnt <= discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
      if (valid && !bus.instr_ready_i && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign discard_cnt_o = discard_cnt;
  assign stall_cnt_o   = stall_cnt;
`endif

endmodule

`default_nettype wire
